// File: rtl/div_seq.sv
// div_seq: multi-cycle DIV/DIVU sequencer beside the EX stage.
// Radix-2 restoring division, one quotient bit per cycle. It requests a
// pipeline stall while busy and returns {remainder, quotient} for the
// HI/LO write path.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_req_o
);

    typedef enum logic [1:0] {
        IDLE,
        BYZERO,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    // Dividend magnitude shifts out at the MSB while quotient bits shift in at the LSB.
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH:0]       rem_shift;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_sub;

    // Operand magnitudes and one restoring-division step.
    always_comb begin
        op1_neg   = signed_i & opdata1_i[WIDTH-1];
        op2_neg   = signed_i & opdata2_i[WIDTH-1];
        mag1      = op1_neg ? -opdata1_i : opdata1_i;
        mag2      = op2_neg ? -opdata2_i : opdata2_i;
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, dvs_q});
        // When rem_ge holds the difference is below the divisor, so WIDTH bits suffice.
        rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        ready_d  = ready_q;

        if (annul_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            ready_d  = 1'b0;
            result_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_d  = 1'b0;
                    result_d = '0;
                    if (start_i) begin
                        cnt_d = '0;
                        if (opdata2_i == '0) begin
                            state_d = BYZERO;
                        end else begin
                            state_d = RUN;
                            dvd_d   = mag1;
                            dvs_d   = mag2;
                            rem_d   = '0;
                            negq_d  = op1_neg ^ op2_neg;
                            negr_d  = op1_neg;
                        end
                    end
                end
                BYZERO: begin
                    // Zero-divisor answer is presented two edges after accept.
                    if (cnt_q == '0) begin
                        cnt_d = CNTW'(1);
                    end else begin
                        state_d  = DONE;
                        ready_d  = 1'b1;
                        result_d = '0;
                    end
                end
                RUN: begin
                    // Counter runs 0..WIDTH: WIDTH iterations, then a sign-fix/finish cycle.
                    if (cnt_q != CNTW'(WIDTH)) begin
                        rem_d = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
                        dvd_d = {dvd_q[WIDTH-2:0], rem_ge};
                        cnt_d = cnt_q + CNTW'(1);
                    end else begin
                        state_d  = DONE;
                        ready_d  = 1'b1;
                        result_d = {(negr_q ? -rem_q : rem_q),
                                    (negq_q ? -dvd_q : dvd_q)};
                    end
                end
                DONE: begin
                    if (!start_i) begin
                        state_d  = IDLE;
                        ready_d  = 1'b0;
                        result_d = '0;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            endcase
        end
    end

    // State, counter, datapath and outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o    = result_q;
    assign ready_o     = ready_q;
    assign stall_req_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized and directed checks of div_seq against an
// arithmetic reference model (plain integer division).
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_req_o;

    int vectors     = 0;
    int miscompares = 0;

    div_seq #(.WIDTH(32), .CNTW(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .signed_i    (signed_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .stall_req_o (stall_req_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {remainder, quotient} by integer arithmetic; x/0 gives 0.
    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = {32'd0, a};
            lb = {32'd0, b};
        end
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    // One full transaction: accept, latency, result, hold in DONE, release.
    task automatic do_div(input string tag, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input int hold, output logic [63:0] res);
        logic [63:0] exp;
        int n;
        int lat;
        bit stall_ok;
        exp = model(s, a, b);
        lat = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        @(posedge clk);
        #1;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        n = 0;
        stall_ok = 1'b1;
        while (!ready_o && n < 100) begin
            if (!stall_req_o) stall_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_stall_busy"}, {63'd0, stall_ok}, 64'd1);
        chk({tag, "_stall_rdy"}, {63'd0, stall_req_o}, 64'd0);
        chk({tag, "_res"}, result_o, exp);
        res = result_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold"}, {ready_o, result_o}, {1'b1, exp});
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_release"}, {ready_o, result_o}, 65'd0);
    endtask

    initial begin
        logic [63:0] res;
        logic [31:0] a, b;
        bit s;
        rst       = 1'b1;
        start_i   = 1'b0;
        annul_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", {ready_o, stall_req_o, result_o}, 66'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle", {ready_o, result_o}, 65'd0);

        // Directed vectors.
        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 0, res);
        chk("divu_100_7_const", res, {32'd2, 32'd14});
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1, res);
        chk("div_m7_2_const", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0, res);
        chk("div_7_m2_const", res, {32'd1, 32'hFFFF_FFFD});
        do_div("div_by0", 1'b1, 32'd1234, 32'd0, 1, res);
        do_div("divu_by0", 1'b0, 32'hDEAD_BEEF, 32'd0, 0, res);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, res);
        chk("div_ovf_const", res, {32'd0, 32'h8000_0000});
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0, res);
        chk("divu_max_1_const", res, {32'd0, 32'hFFFF_FFFF});

        // Annul on RUN cycle 10, then an immediate new request.
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        #1;
        chk("annul_stall", {63'd0, stall_req_o}, 64'd0);
        @(posedge clk);
        #1;
        chk("annul_out", {ready_o, result_o}, 65'd0);
        annul_i = 1'b0;
        do_div("after_annul", 1'b0, 32'd50, 32'd5, 0, res);
        chk("after_annul_const", res, {32'd0, 32'd10});

        // Reset mid-run.
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = 1'b1;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid", {ready_o, result_o}, 65'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idle", {ready_o, result_o}, 65'd0);
        do_div("hold5", 1'b1, 32'hFFFF_FC18, 32'd7, 5, res);

        // Randomized vectors with bias towards boundary operands.
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            do_div("rand", s, a, b, $urandom_range(0, 3), res);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
